operand_fetch: RTL

Multicycle operand-fetch and write-back sequencer that sits between the instruction decoder/ALU and `regBank` in the 8-bit processor. `regBank` has a single shared select (`rs`) for read and write, so two-operand instructions cannot read both sources and write the result at once. This block accepts an issued instruction and reads source A, then source B, through that one port. It then hands the operands to the ALU, waits for the result, and writes it to the destination register.

---
 rtl/proc_pkg.sv | 16 +
 rtl/operand_fetch_if.sv | 33 +++
 rtl/operand_fetch.sv | 106 ++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the 8-bit processor datapath: widths and the
// operand-fetch sequencer state encoding used by RTL, control unit and bench.
package proc_pkg;

    localparam int DATA_W = 8;
    localparam int RSEL_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_EXEC = 3'd3,
        ST_WB   = 3'd4
    } of_state_e;

endpackage

// File: rtl/operand_fetch_if.sv
// Bundle of issue, ALU and regBank signals around the operand-fetch sequencer.
// slave = the sequencer itself, master = its environment.
interface operand_fetch_if #(
    parameter int DATA_W = proc_pkg::DATA_W,
    parameter int RSEL_W = proc_pkg::RSEL_W
);
    logic              start;
    logic [RSEL_W-1:0] ra;
    logic [RSEL_W-1:0] rb;
    logic [RSEL_W-1:0] rd;
    logic              kill;
    logic              busy;
    logic              op_valid;
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              done;
    logic              WR;
    logic [RSEL_W-1:0] rs;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] regVal;

    modport slave (
        input  start, ra, rb, rd, kill, res_valid, res_data, regVal,
        output busy, op_valid, opA, opB, done, WR, rs, data
    );

    modport master (
        output start, ra, rb, rd, kill, res_valid, res_data, regVal,
        input  busy, op_valid, opA, opB, done, WR, rs, data
    );
endinterface

// File: rtl/operand_fetch.sv
// Sequences two reads and one write through regBank's single shared select,
// handing the operands to the ALU between the reads and the write-back.
module operand_fetch
    import proc_pkg::*;
#(
    parameter int DATA_W = proc_pkg::DATA_W,
    parameter int RSEL_W = proc_pkg::RSEL_W
) (
    input  logic            clk,
    input  logic            rst_n,
    operand_fetch_if.slave  bus
);

    of_state_e         state_r;
    of_state_e         state_nxt_s;
    logic [RSEL_W-1:0] ra_r;
    logic [RSEL_W-1:0] rb_r;
    logic [RSEL_W-1:0] rd_r;
    logic [DATA_W-1:0] opa_r;
    logic [DATA_W-1:0] opb_r;
    logic [DATA_W-1:0] res_r;
    logic [RSEL_W-1:0] rs_s;

    // Next-state decode; kill wins over res_valid and cannot abort WB.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_nxt_s = ST_RD_A;
                else           state_nxt_s = ST_IDLE;
            end
            ST_RD_A: begin
                if (bus.kill) state_nxt_s = ST_IDLE;
                else          state_nxt_s = ST_RD_B;
            end
            ST_RD_B: begin
                if (bus.kill) state_nxt_s = ST_IDLE;
                else          state_nxt_s = ST_EXEC;
            end
            ST_EXEC: begin
                if (bus.kill)           state_nxt_s = ST_IDLE;
                else if (bus.res_valid) state_nxt_s = ST_WB;
                else                    state_nxt_s = ST_EXEC;
            end
            ST_WB:   state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_nxt_s;
    end

    // Register selects are only taken on an accepted issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra_r <= {RSEL_W{1'b0}};
            rb_r <= {RSEL_W{1'b0}};
            rd_r <= {RSEL_W{1'b0}};
        end else if ((state_r == ST_IDLE) && bus.start) begin
            ra_r <= bus.ra;
            rb_r <= bus.rb;
            rd_r <= bus.rd;
        end
    end

    // Operand capture from the shared read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_r <= {DATA_W{1'b0}};
            opb_r <= {DATA_W{1'b0}};
        end else if (state_r == ST_RD_A) begin
            opa_r <= bus.regVal;
        end else if (state_r == ST_RD_B) begin
            opb_r <= bus.regVal;
        end
    end

    // Result capture; a killed instruction leaves the last written value on data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                                  res_r <= {DATA_W{1'b0}};
        else if ((state_r == ST_EXEC) && bus.res_valid && !bus.kill) res_r <= bus.res_data;
    end

    // Select mux: sources during the reads, destination otherwise.
    always_comb begin
        rs_s = rd_r;
        case (state_r)
            ST_RD_A: rs_s = ra_r;
            ST_RD_B: rs_s = rb_r;
            default: rs_s = rd_r;
        endcase
    end

    assign bus.busy     = (state_r != ST_IDLE);
    assign bus.op_valid = (state_r == ST_EXEC);
    assign bus.done     = (state_r == ST_WB);
    assign bus.WR       = (state_r == ST_WB);
    assign bus.rs       = rs_s;
    assign bus.data     = res_r;
    assign bus.opA      = opa_r;
    assign bus.opB      = opb_r;

endmodule
